alu_mdu_unit: RTL and testbench
===============================

ALU_MDU_UNIT -- requirements
Module: alu_mdu_unit

Interface
REQ-001 SHALL have parameter XLEN, 32, datapath width in bits (legal: 32, 64).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports in_valid  input  1  and in_ready  output  1  request handshake.
REQ-005 SHALL have ports opb5  input  1, funct3  input  3, funct7b5  input  1, funct7b0  input  1, ALUOp  input  2  instruction decode fields.
REQ-006 SHALL have ports src_a  input  XLEN  and src_b  input  XLEN  operands.
REQ-007 SHALL have ports out_valid  output  1  and out_ready  input  1  response handshake.
REQ-008 SHALL have ports result  output  XLEN, branch_taken  output  1, busy  output  1 (high in MDU_BUSY).

Function
REQ-009 SHALL encode ALU ops: add 0000, sub 0001, and 0010, or 0011, xor 0100, sra 0101, sll 0110, srl 0111, sltu 1000, slt 1001.
REQ-010 SHALL decode ALUOp 00 as add; ALUOp 01 as branch: BEQ/BNE sub, BLT/BGE slt, BLTU/BGEU sltu; other funct3 gives result 0, branch_taken 0.
REQ-011 SHALL decode ALUOp 1x by funct3; sub when funct3=000 and funct7b5&opb5; sra when funct3=101 and funct7b5 (shift immediates included).
REQ-012 SHALL use src_b[log2(XLEN)-1:0] as the shift amount.
REQ-013 SHALL set branch_taken for BEQ (a==b), BNE (a!=b), BLT, BGE, BLTU, BGEU per RV semantics; 0 for non-branch ops.
REQ-014 SHALL implement states IDLE, MDU_BUSY, OUT_HOLD.
REQ-015 SHALL assert in_ready only in IDLE, or in OUT_HOLD with out_ready high.
REQ-016 SHALL, on accepted non-M op, register result and branch_taken and enter OUT_HOLD next cycle (latency 1).
REQ-017 SHALL treat ALUOp=10, opb5=1, funct7b0=1 as M op: funct3 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-018 SHALL, on accepted M op, enter MDU_BUSY for exactly XLEN cycles, then OUT_HOLD (latency XLEN+1).
REQ-019 SHALL, on divide by zero, return quotient all-ones and remainder = src_a.
REQ-020 SHALL, on signed overflow (most-negative / -1), return quotient = most-negative and remainder 0.
REQ-021 SHALL hold out_valid, result and branch_taken stable in OUT_HOLD until out_ready.
REQ-022 SHALL, in OUT_HOLD with out_ready and in_valid both high, complete the output and accept the new request in the same cycle.
REQ-023 SHALL, in OUT_HOLD with out_ready high and no new request, return to IDLE.
REQ-024 SHALL ignore in_valid while in MDU_BUSY; operands are captured at acceptance only.

Reset
REQ-025 SHALL, on reset, immediately enter IDLE with out_valid 0, result 0, branch_taken 0, busy 0, in_ready 1.
REQ-026 SHALL abandon an in-flight M op on reset mid-operation, producing no output.

Configuration
REQ-027 SHALL compile MDU_BUSY and the M-op datapath only when ALU_MDU_UNIT_MDU_EN is defined.
REQ-028 SHALL, without ALU_MDU_UNIT_MDU_EN, ignore funct7b0, decode M-encoded requests as base ALU ops by funct3, and complete every op with latency 1.

Structure
REQ-029 SHALL place ALU op encodings, the state enum and the M-op enum in shared package alu_pkg.
REQ-030 SHALL implement the iterative shift-add multiplier / restoring divider as sub-module mdu_iter (start, done, op, operands, result).

Verification
REQ-031 SHALL test: XLEN=32, ALUOp=10, funct3=000, opb5=1, funct7b5=1, a=5, b=7 -> result 0xFFFFFFFE after 1 cycle.
REQ-032 SHALL test: BLT with a=0xFFFFFFFF, b=1 -> branch_taken 1; BLTU with the same operands -> branch_taken 0.
REQ-033 SHALL test: MULH with a=0x80000000, b=2 -> result 0xFFFFFFFF, out_valid exactly 33 cycles after acceptance.
REQ-034 SHALL test: DIV by 0 with a=9 -> 0xFFFFFFFF; REM with a=0x80000000, b=0xFFFFFFFF -> 0.
REQ-035 SHALL test: out_ready held low 5 cycles -> result stable, in_ready 0; back-to-back accept on release.
REQ-036 SHALL test: reset at cycle 10 of a DIVU -> IDLE, no out_valid; the next add completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU/MDU slice: ALU ops, control FSM states, M-extension ops.
// The M datapath is only built when ALU_MDU_UNIT_MDU_EN is defined.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRA  = 4'b0101,
        ALU_SLL  = 4'b0110,
        ALU_SRL  = 4'b0111,
        ALU_SLTU = 4'b1000,
        ALU_SLT  = 4'b1001
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        MDU_BUSY = 2'b01,
        OUT_HOLD = 2'b10
    } state_e;

    typedef enum logic [2:0] {
        M_MUL    = 3'b000,
        M_MULH   = 3'b001,
        M_MULHSU = 3'b010,
        M_MULHU  = 3'b011,
        M_DIV    = 3'b100,
        M_DIVU   = 3'b101,
        M_REM    = 3'b110,
        M_REMU   = 3'b111
    } mdu_op_e;

    typedef struct packed {
        logic    ok;
        alu_op_e op;
    } alu_dec_t;

    // ok=0 marks branch funct3 values with no defined comparison (result and branch forced to 0)
    function automatic alu_dec_t alu_decode(input logic [1:0] alu_sel, input logic [2:0] funct3,
                                            input logic opb5, input logic funct7b5);
        alu_dec_t d;
        d.ok = 1'b1;
        d.op = ALU_ADD;
        if (alu_sel == 2'b01) begin
            case (funct3)
                3'b000, 3'b001: d.op = ALU_SUB;
                3'b100, 3'b101: d.op = ALU_SLT;
                3'b110, 3'b111: d.op = ALU_SLTU;
                default:        d.ok = 1'b0;
            endcase
        end else if (alu_sel[1]) begin
            case (funct3)
                3'b000:  d.op = (funct7b5 & opb5) ? ALU_SUB : ALU_ADD;
                3'b001:  d.op = ALU_SLL;
                3'b010:  d.op = ALU_SLT;
                3'b011:  d.op = ALU_SLTU;
                3'b100:  d.op = ALU_XOR;
                3'b101:  d.op = funct7b5 ? ALU_SRA : ALU_SRL;
                3'b110:  d.op = ALU_OR;
                default: d.op = ALU_AND;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/alu_mdu_unit_mdu_iter.sv
// Iterative MDU: shift-add multiplier and restoring divider on operand magnitudes,
// one step per cycle for XLEN cycles; done is high during the final step.
module mdu_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    mdu_op_e         op_in, op_r;
    logic            signed_a, signed_b, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN-1:0] hi, lo, m, hi_n, lo_n;
    logic            sa, sb, div0, running;
    logic [CW-1:0]   cnt;
    logic [XLEN:0]   mul_sum, div_shift;
    logic [XLEN-1:0] div_diff;
    logic            div_ge;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0] quo, rem;

    always_comb begin
        op_in    = mdu_op_e'(op);
        signed_a = op_in inside {M_MULH, M_MULHSU, M_DIV, M_REM};
        signed_b = op_in inside {M_MULH, M_DIV, M_REM};
        a_neg    = signed_a & a[XLEN-1];
        b_neg    = signed_b & b[XLEN-1];
        a_mag    = a_neg ? -a : a;
        b_mag    = b_neg ? -b : b;
    end

    // hi/lo hold {partial product, multiplier} for MUL and {remainder, quotient} for DIV
    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
        div_shift = {hi, lo[XLEN-1]};
        div_ge    = (div_shift >= {1'b0, m});
        div_diff  = div_shift[XLEN-1:0] - m;
        if (op_r inside {M_DIV, M_DIVU, M_REM, M_REMU}) begin
            hi_n = div_ge ? div_diff : div_shift[XLEN-1:0];
            lo_n = {lo[XLEN-2:0], div_ge};
        end else begin
            hi_n = mul_sum[XLEN:1];
            lo_n = {mul_sum[0], lo[XLEN-1:1]};
        end
        prod   = {hi_n, lo_n};
        prod_s = (sa ^ sb) ? -prod : prod;
        // divide-by-zero keeps the all-ones quotient unsigned; the remainder then equals a
        quo    = ((sa ^ sb) && !div0) ? -lo_n : lo_n;
        rem    = sa ? -hi_n : hi_n;
        case (op_r)
            M_MUL:                     result = prod_s[XLEN-1:0];
            M_MULH, M_MULHSU, M_MULHU: result = prod_s[2*XLEN-1:XLEN];
            M_DIV, M_DIVU:             result = quo;
            default:                   result = rem;
        endcase
        done = running && (cnt == CW'(XLEN - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi      <= '0;
            lo      <= '0;
            m       <= '0;
            op_r    <= M_MUL;
            sa      <= 1'b0;
            sb      <= 1'b0;
            div0    <= 1'b0;
            running <= 1'b0;
            cnt     <= '0;
        end else if (start) begin
            hi      <= '0;
            lo      <= a_mag;
            m       <= b_mag;
            op_r    <= op_in;
            sa      <= a_neg;
            sb      <= b_neg;
            div0    <= (b == '0);
            running <= 1'b1;
            cnt     <= '0;
        end else if (running) begin
            hi  <= hi_n;
            lo  <= lo_n;
            cnt <= cnt + CW'(1);
            if (done) running <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_mdu_unit.sv
// RV-style ALU with branch compare and optional iterative M unit behind a valid/ready pair.
// Define ALU_MDU_UNIT_MDU_EN to build the MDU_BUSY path and the M-op datapath.
module alu_mdu_unit
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            opb5,
    input  logic [2:0]      funct3,
    input  logic            funct7b5,
    input  logic            funct7b0,
    input  logic [1:0]      ALUOp,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            branch_taken,
    output logic            busy
);

    localparam int SHW = $clog2(XLEN);

    state_e          state;
    alu_dec_t        dec;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_res;
    logic            bt;
    logic            accept;
    logic            is_m;

    assign in_ready  = (state == IDLE) || ((state == OUT_HOLD) && out_ready);
    assign out_valid = (state == OUT_HOLD);
    assign busy      = (state == MDU_BUSY);
    assign accept    = in_valid && in_ready;

    always_comb begin
        dec     = alu_decode(ALUOp, funct3, opb5, funct7b5);
        shamt   = src_b[SHW-1:0];
        alu_res = '0;
        if (dec.ok) begin
            case (dec.op)
                ALU_ADD:  alu_res = src_a + src_b;
                ALU_SUB:  alu_res = src_a - src_b;
                ALU_AND:  alu_res = src_a & src_b;
                ALU_OR:   alu_res = src_a | src_b;
                ALU_XOR:  alu_res = src_a ^ src_b;
                ALU_SRA:  alu_res = $unsigned($signed(src_a) >>> shamt);
                ALU_SLL:  alu_res = src_a << shamt;
                ALU_SRL:  alu_res = src_a >> shamt;
                ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, src_a < src_b};
                ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
                default:  alu_res = '0;
            endcase
        end
        bt = 1'b0;
        if (ALUOp == 2'b01) begin
            case (funct3)
                3'b000:         bt = (alu_res == '0);
                3'b001:         bt = (alu_res != '0);
                3'b100, 3'b110: bt = alu_res[0];
                3'b101, 3'b111: bt = ~alu_res[0];
                default:        bt = 1'b0;
            endcase
        end
    end

`ifdef ALU_MDU_UNIT_MDU_EN
    logic            mdu_done;
    logic [XLEN-1:0] mdu_result;

    assign is_m = (ALUOp == 2'b10) && opb5 && funct7b0;

    mdu_iter #(.XLEN(XLEN)) u_mdu (
        .clk    (clk),
        .reset  (reset),
        .start  (accept && is_m),
        .op     (funct3),
        .a      (src_a),
        .b      (src_b),
        .done   (mdu_done),
        .result (mdu_result)
    );
`else
    logic unused_funct7b0;
    assign unused_funct7b0 = funct7b0;
    assign is_m            = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            result       <= '0;
            branch_taken <= 1'b0;
        end else begin
            case (state)
                IDLE, OUT_HOLD: begin
                    if (accept) begin
                        if (is_m) begin
                            state <= MDU_BUSY;
                        end else begin
                            result       <= alu_res;
                            branch_taken <= bt;
                            state        <= OUT_HOLD;
                        end
                    end else if ((state == OUT_HOLD) && out_ready) begin
                        state <= IDLE;
                    end
                end
`ifdef ALU_MDU_UNIT_MDU_EN
                MDU_BUSY: begin
                    if (mdu_done) begin
                        result       <= mdu_result;
                        branch_taken <= 1'b0;
                        state        <= OUT_HOLD;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mdu_unit.sv
// Self-checking bench for alu_mdu_unit (XLEN=32); M-op scenarios run when ALU_MDU_UNIT_MDU_EN is defined.
module tb_alu_mdu_unit;

    localparam int XLEN = 32;
`ifdef ALU_MDU_UNIT_MDU_EN
    localparam bit MDU_EN = 1'b1;
`else
    localparam bit MDU_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, opb5, funct7b5, funct7b0;
    logic        out_valid, out_ready, branch_taken, busy;
    logic [2:0]  funct3;
    logic [1:0]  ALUOp;
    logic [31:0] src_a, src_b, result;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    alu_mdu_unit #(.XLEN(XLEN)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .opb5         (opb5),
        .funct3       (funct3),
        .funct7b5     (funct7b5),
        .funct7b0     (funct7b0),
        .ALUOp        (ALUOp),
        .src_a        (src_a),
        .src_b        (src_b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .branch_taken (branch_taken),
        .busy         (busy)
    );

    function automatic bit ref_is_m(input logic [1:0] aop, input logic ob5, input logic f7b0);
        return MDU_EN && (aop == 2'b10) && ob5 && f7b0;
    endfunction

    function automatic logic [31:0] ref_result(input logic [1:0] aop, input logic [2:0] f3,
                                               input logic ob5, input logic f7b5, input logic f7b0,
                                               input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] as, bs;
        longint             pa, pb, pbu, p;
        longint unsigned    ua, ub, pu;
        int                 sh;
        as = a; bs = b; sh = int'(b[4:0]);
        pa = as; pb = bs; pbu = longint'({32'b0, b});
        ua = {32'b0, a}; ub = {32'b0, b};
        if (ref_is_m(aop, ob5, f7b0)) begin
            case (f3)
                3'd0: begin pu = ua * ub; return pu[31:0]; end
                3'd1: begin p = pa * pb; return p[63:32]; end
                3'd2: begin p = pa * pbu; return p[63:32]; end
                3'd3: begin pu = ua * ub; return pu[63:32]; end
                3'd4: return (b == 0) ? 32'hFFFF_FFFF :
                             (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 : as / bs;
                3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
                3'd6: return (b == 0) ? a :
                             (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : as % bs;
                default: return (b == 0) ? a : a % b;
            endcase
        end
        if (aop == 2'b00) return a + b;
        if (aop == 2'b01) begin
            case (f3)
                3'd0, 3'd1: return a - b;
                3'd4, 3'd5: return (as < bs) ? 32'd1 : 32'd0;
                3'd6, 3'd7: return (a < b) ? 32'd1 : 32'd0;
                default:    return 32'd0;
            endcase
        end
        case (f3)
            3'd0:    return (f7b5 && ob5) ? a - b : a + b;
            3'd1:    return a << sh;
            3'd2:    return (as < bs) ? 32'd1 : 32'd0;
            3'd3:    return (a < b) ? 32'd1 : 32'd0;
            3'd4:    return a ^ b;
            3'd5:    return f7b5 ? 32'(as >>> sh) : a >> sh;
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic ref_branch(input logic [1:0] aop, input logic [2:0] f3,
                                        input logic [31:0] a, input logic [31:0] b);
        if (aop != 2'b01) return 1'b0;
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) < $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a < b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    // Issues one request at the sample point and reports cycles from acceptance to out_valid
    task automatic run_op(input logic [1:0] aop, input logic [2:0] f3, input logic ob5,
                          input logic f7b5, input logic f7b0, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] res, output logic bt,
                          output int lat);
        int w;
        ALUOp = aop; funct3 = f3; opb5 = ob5; funct7b5 = f7b5; funct7b0 = f7b0;
        src_a = a; src_b = b; in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 100) begin @(posedge clk); #1; w++; end
        @(posedge clk); #1;
        in_valid = 1'b0; src_a = $urandom; src_b = $urandom;
        lat = 1;
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        res = result; bt = branch_taken;
    endtask

    task automatic test_reset();
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++;
        if (result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h expected 00000000", result); end
        checks++;
        if (branch_taken !== 1'b0) begin errors++; $display("FAIL reset_branch: got %b expected 0", branch_taken); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++;
    endtask

    task automatic test_sub();
        logic [31:0] res; logic bt; int lat;
        run_op(2'b10, 3'b000, 1'b1, 1'b1, 1'b0, 32'd5, 32'd7, res, bt, lat);
        if (res !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sub_result: got %h expected fffffffe", res); end
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL sub_latency: got %0d expected 1", lat); end
        checks++;
    endtask

    task automatic test_branch();
        logic [31:0] res; logic bt; int lat;
        run_op(2'b01, 3'b100, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, res, bt, lat);
        if (bt !== 1'b1) begin errors++; $display("FAIL blt_taken: got %b expected 1", bt); end
        checks++;
        run_op(2'b01, 3'b110, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, res, bt, lat);
        if (bt !== 1'b0) begin errors++; $display("FAIL bltu_taken: got %b expected 0", bt); end
        checks++;
    endtask

    task automatic test_random_alu();
        logic [31:0] a, b, res, exp_res; logic [2:0] f3; logic [1:0] aop;
        logic ob5, f7b5, f7b0, bt, exp_bt; int lat;
        for (int i = 0; i < 80; i++) begin
            aop = 2'($urandom_range(0, 3)); f3 = 3'($urandom_range(0, 7));
            ob5 = 1'($urandom); f7b5 = 1'($urandom); f7b0 = 1'($urandom);
            if (ref_is_m(aop, ob5, f7b0)) f7b0 = 1'b0;
            a = pick_operand(); b = ($urandom_range(0, 3) == 0) ? a : pick_operand();
            exp_res = ref_result(aop, f3, ob5, f7b5, f7b0, a, b);
            exp_bt  = ref_branch(aop, f3, a, b);
            run_op(aop, f3, ob5, f7b5, f7b0, a, b, res, bt, lat);
            if (res !== exp_res) begin
                errors++;
                $display("FAIL alu_result op=%b f3=%0d a=%h b=%h: got %h expected %h", aop, f3, a, b, res, exp_res);
            end
            checks++;
            if (bt !== exp_bt) begin
                errors++;
                $display("FAIL alu_branch op=%b f3=%0d a=%h b=%h: got %b expected %b", aop, f3, a, b, bt, exp_bt);
            end
            checks++;
            if (lat !== 1) begin errors++; $display("FAIL alu_latency: got %0d expected 1", lat); end
            checks++;
        end
    endtask

`ifdef ALU_MDU_UNIT_MDU_EN
    task automatic test_mdu();
        logic [31:0] a, b, res, exp_res; logic [2:0] f3; logic bt; int lat;
        run_op(2'b10, 3'b001, 1'b1, 1'b0, 1'b1, 32'h8000_0000, 32'd2, res, bt, lat);
        if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mulh_result: got %h expected ffffffff", res); end
        checks++;
        if (lat !== 33) begin errors++; $display("FAIL mulh_latency: got %0d expected 33", lat); end
        checks++;
        run_op(2'b10, 3'b100, 1'b1, 1'b0, 1'b1, 32'd9, 32'd0, res, bt, lat);
        if (res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_by_zero: got %h expected ffffffff", res); end
        checks++;
        run_op(2'b10, 3'b110, 1'b1, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, res, bt, lat);
        if (res !== 32'd0) begin errors++; $display("FAIL rem_overflow: got %h expected 00000000", res); end
        checks++;
        for (int i = 0; i < 32; i++) begin
            f3 = 3'(i % 8); a = pick_operand(); b = pick_operand();
            exp_res = ref_result(2'b10, f3, 1'b1, 1'b0, 1'b1, a, b);
            run_op(2'b10, f3, 1'b1, 1'b0, 1'b1, a, b, res, bt, lat);
            if (res !== exp_res) begin
                errors++;
                $display("FAIL mdu_result f3=%0d a=%h b=%h: got %h expected %h", f3, a, b, res, exp_res);
            end
            checks++;
            if (lat !== 33 || bt !== 1'b0) begin
                errors++;
                $display("FAIL mdu_latency_branch: got lat=%0d bt=%b expected lat=33 bt=0", lat, bt);
            end
            checks++;
        end
    endtask

    task automatic test_busy_ignores_input();
        int lat;
        ALUOp = 2'b10; funct3 = 3'b101; opb5 = 1'b1; funct7b5 = 1'b0; funct7b0 = 1'b1;
        src_a = 32'd100; src_b = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        ALUOp = 2'b00; src_a = 32'd1; src_b = 32'd1;
        for (int i = 0; i < 4; i++) begin @(posedge clk); #1; end
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL busy_flags: got busy=%b in_ready=%b expected 1 0", busy, in_ready);
        end
        checks++;
        for (int i = 0; i < 15; i++) begin @(posedge clk); #1; end
        in_valid = 1'b0;
        lat = 20;
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        if (result !== 32'd14 || lat !== 33) begin
            errors++; $display("FAIL busy_divu: got %h lat=%0d expected 0000000e lat=33", result, lat);
        end
        checks++;
        @(posedge clk); #1;
    endtask
`else
    task automatic test_m_as_alu();
        logic [31:0] a, b, res, exp_res; logic [2:0] f3; logic f7b5, bt; int lat;
        run_op(2'b10, 3'b000, 1'b1, 1'b0, 1'b1, 32'd5, 32'd7, res, bt, lat);
        if (res !== 32'd12 || lat !== 1) begin
            errors++; $display("FAIL m_encoded_add: got %h lat=%0d expected 0000000c lat=1", res, lat);
        end
        checks++;
        for (int i = 0; i < 16; i++) begin
            f3 = 3'(i % 8); f7b5 = 1'($urandom); a = pick_operand(); b = pick_operand();
            exp_res = ref_result(2'b10, f3, 1'b1, f7b5, 1'b1, a, b);
            run_op(2'b10, f3, 1'b1, f7b5, 1'b1, a, b, res, bt, lat);
            if (res !== exp_res || lat !== 1) begin
                errors++;
                $display("FAIL m_encoded_alu f3=%0d: got %h lat=%0d expected %h lat=1", f3, res, lat, exp_res);
            end
            checks++;
        end
    endtask
`endif

    task automatic test_backpressure();
        logic [31:0] a1, b1, a2, b2, exp1, exp2;
        @(posedge clk); #1;
        a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
        exp1 = a1 ^ b1; exp2 = a2 + b2;
        out_ready = 1'b0;
        ALUOp = 2'b10; funct3 = 3'b100; opb5 = 1'b1; funct7b5 = 1'b0; funct7b0 = 1'b0;
        src_a = a1; src_b = b1; in_valid = 1'b1;
        @(posedge clk); #1;
        ALUOp = 2'b00; src_a = a2; src_b = b2;
        for (int i = 0; i < 5; i++) begin
            if (out_valid !== 1'b1 || result !== exp1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d: got valid=%b result=%h ready=%b expected 1 %h 0",
                         i, out_valid, result, in_ready, exp1);
            end
            checks++;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b expected 1", in_ready); end
        checks++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (out_valid !== 1'b1 || result !== exp2) begin
            errors++; $display("FAIL back_to_back: got valid=%b result=%h expected 1 %h", out_valid, result, exp2);
        end
        checks++;
        @(posedge clk); #1;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL return_idle: got %b expected 0", out_valid); end
        checks++;
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] a, b, res; logic bt; int lat, seen;
`ifdef ALU_MDU_UNIT_MDU_EN
        ALUOp = 2'b10; funct3 = 3'b101; opb5 = 1'b1; funct7b0 = 1'b1;
`else
        ALUOp = 2'b00; funct3 = 3'b000; opb5 = 1'b0; funct7b0 = 1'b0;
        out_ready = 1'b0;
`endif
        funct7b5 = 1'b0; src_a = 32'hDEAD_BEEF; src_b = 32'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin @(posedge clk); #1; end
        #2 reset = 1'b1;
        #1;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || result !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset_state: got valid=%b busy=%b ready=%b result=%h expected 0 0 1 0",
                     out_valid, busy, in_ready, result);
        end
        checks++;
        @(posedge clk); #1;
        reset = 1'b0; out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        if (seen !== 0) begin errors++; $display("FAIL abandoned_output: got %0d valid cycles expected 0", seen); end
        checks++;
        a = $urandom; b = $urandom;
        run_op(2'b00, 3'b000, 1'b0, 1'b0, 1'b0, a, b, res, bt, lat);
        if (res !== a + b || lat !== 1) begin
            errors++; $display("FAIL add_after_reset: got %h lat=%0d expected %h lat=1", res, lat, a + b);
        end
        checks++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        ALUOp = 2'b00; funct3 = 3'b000; opb5 = 1'b0; funct7b5 = 1'b0; funct7b0 = 1'b0;
        src_a = '0; src_b = '0;
        #1;
        test_reset();
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        test_sub();
        test_branch();
        test_random_alu();
`ifdef ALU_MDU_UNIT_MDU_EN
        test_mdu();
        test_busy_ignores_input();
`else
        test_m_as_alu();
`endif
        test_backpressure();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
